// File: rtl/matrix_tx_sequencer.sv
// Frame sequencer for the LED-matrix output stage: fetches each frame-buffer word
// through a 1-cycle read port and presents it with one new_image/new_column/next_data strobe.
module matrix_tx_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int WORDS_PER_COLUMN = 4,
  parameter int COLUMNS          = 16,
  parameter int ADDR_W           = (COLUMNS * WORDS_PER_COLUMN > 1) ?
                                   $clog2(COLUMNS * WORDS_PER_COLUMN) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               rd_en,
  output logic [ADDR_W-1:0]                  rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_in,
  output logic                               new_image,
  output logic                               new_column,
  output logic                               next_data,
  output logic                               extra_bit,
  input  logic                               tx_finish,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int DW     = CHANNEL_NUMBER * SPI_SIZE;
  localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLUMNS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_COLUMN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic [1:0]          drain_q, drain_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]       data_in_q, data_in_d;
  logic                new_image_q, new_image_d;
  logic                new_column_q, new_column_d;
  logic                next_data_q, next_data_d;
  logic                extra_bit_q, extra_bit_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic last_word, last_col;

  assign last_word = (word_q == LAST_WORD);
  assign last_col  = (col_q == LAST_COL);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    word_d       = word_q;
    pending_d    = pending_q;
    drain_d      = drain_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    data_in_d    = data_in_q;
    new_image_d  = 1'b0;
    new_column_d = 1'b0;
    next_data_d  = 1'b0;
    extra_bit_d  = extra_bit_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // a start coinciding with the frame_done pulse is still part of the old frame
        if (start && !frame_done_q) begin
          state_d   = S_FETCH;
          busy_d    = 1'b1;
          col_d     = '0;
          word_d    = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        pending_d = rd_data;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (tx_finish) begin
          data_in_d    = pending_q;
          new_image_d  = (word_q == '0) && (col_q == '0);
          new_column_d = (word_q == '0) && (col_q != '0);
          next_data_d  = (word_q != '0);
          extra_bit_d  = last_word;
          if (last_word && last_col) begin
            state_d = S_DRAIN;
            drain_d = 2'd2;
          end else begin
            // linear address tracks col*WORDS_PER_COLUMN+word without a multiplier
            state_d   = S_FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            if (last_word) begin
              word_d = '0;
              col_d  = col_q + 1'b1;
            end else begin
              word_d = word_q + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 1'b1;
        end else if (tx_finish) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      word_q       <= '0;
      pending_q    <= '0;
      drain_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      data_in_q    <= '0;
      new_image_q  <= 1'b0;
      new_column_q <= 1'b0;
      next_data_q  <= 1'b0;
      extra_bit_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      word_q       <= word_d;
      pending_q    <= pending_d;
      drain_q      <= drain_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      data_in_q    <= data_in_d;
      new_image_q  <= new_image_d;
      new_column_q <= new_column_d;
      next_data_q  <= next_data_d;
      extra_bit_q  <= extra_bit_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign data_in    = data_in_q;
  assign new_image  = new_image_q;
  assign new_column = new_column_q;
  assign next_data  = next_data_q;
  assign extra_bit  = extra_bit_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_tx_sequencer.sv
// Bench for matrix_tx_sequencer: two configurations (2x2 and 3x1) share stimulus and are
// each checked every cycle against a word-index/cycle-gap model, plus literal frame checks.
module tb_matrix_tx_sequencer;

  localparam int CN = 3;
  localparam int SS = 8;
  localparam int DW = CN * SS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic        fd_echo  = 1'b0;
  logic        load_lit = 1'b0;
  logic        reload   = 1'b0;
  logic        bp_rand  = 1'b0;
  int          bp_max   = 0;
  int unsigned cyc      = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;
  logic [DW-1:0] lit [4] = '{24'h0F0F0F, 24'hF0F0F0, 24'hFFFFFF, 24'h000000};

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int C  = (g == 0) ? 2 : 3;
    localparam int W  = (g == 0) ? 2 : 1;
    localparam int N  = C * W;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] mem [N];
    logic          rd_en, new_image, new_column, next_data, extra_bit, busy, frame_done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] data_in;
    logic          tx_finish = 1'b1;
    logic          echo = 1'b0;
    logic          st;
    int            txcnt = 0;

    assign st = start | echo;

    matrix_tx_sequencer #(
      .CHANNEL_NUMBER(CN), .SPI_SIZE(SS), .WORDS_PER_COLUMN(W), .COLUMNS(C), .ADDR_W(AW)
    ) dut (
      .clk(clk), .rst(rst), .start(st), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .data_in(data_in), .new_image(new_image), .new_column(new_column), .next_data(next_data),
      .extra_bit(extra_bit), .tx_finish(tx_finish), .busy(busy), .frame_done(frame_done)
    );

    // frame buffer with 1-cycle read latency
    always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (load_lit) for (int i = 0; i < N; i++) mem[i] <= lit[i % 4];
      if (reload)   for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
    end

    // output stage: drops tx_finish for a (possibly random) time after each strobe
    initial forever begin
      @(negedge clk);
      if (!rst) txcnt = 0;
      else if (new_image | new_column | next_data) txcnt = bp_rand ? $urandom_range(bp_max, 0) : bp_max;
      else if (txcnt > 0) txcnt--;
      tx_finish = (txcnt == 0);
      echo = fd_echo & frame_done;
    end

    // reference: word k of the frame issues on the first edge >= 3 cycles after the
    // previous event (start or strobe) that samples tx_finish high
    logic          e_rd_en = 0, e_ni = 0, e_nc = 0, e_nd = 0, e_xb = 0, e_busy = 0, e_fd = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    int            m_k = 0, m_gap = 0;

    initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        e_rd_en = 0; e_ni = 0; e_nc = 0; e_nd = 0; e_xb = 0; e_busy = 0; e_fd = 0;
        e_addr = '0; e_data = '0; m_k = 0; m_gap = 0;
      end else begin
        e_rd_en = 0; e_ni = 0; e_nc = 0; e_nd = 0;
        if (!e_busy) begin
          if (st && !e_fd) begin
            e_busy = 1; e_rd_en = 1; e_addr = '0; m_k = 0; m_gap = 0;
          end
          e_fd = 0;
        end else begin
          m_gap++;
          if (m_gap >= 3 && tx_finish) begin
            if (m_k < N) begin
              e_data = mem[m_k];
              e_xb   = (m_k % W == W - 1);
              e_ni   = (m_k == 0);
              e_nc   = (m_k != 0) && (m_k % W == 0);
              e_nd   = (m_k % W != 0);
              m_k++;
              m_gap = 0;
              if (m_k < N) begin
                e_rd_en = 1;
                e_addr  = AW'(m_k);
              end
            end else begin
              e_fd = 1;
              e_busy = 0;
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      n_cmp++;
      if ({rd_en, rd_addr, data_in, new_image, new_column, next_data, extra_bit, busy, frame_done} !==
          {e_rd_en, e_addr, e_data, e_ni, e_nc, e_nd, e_xb, e_busy, e_fd}) begin
        n_bad++;
        $display("FAIL cfg%0d outputs @cyc %0d: got rd_en=%b addr=%0d data=%h ni/nc/nd=%b%b%b xb=%b busy=%b fd=%b; expected rd_en=%b addr=%0d data=%h ni/nc/nd=%b%b%b xb=%b busy=%b fd=%b",
                 g, cyc, rd_en, rd_addr, data_in, new_image, new_column, next_data, extra_bit, busy, frame_done,
                 e_rd_en, e_addr, e_data, e_ni, e_nc, e_nd, e_xb, e_busy, e_fd);
      end
    end
  end

  // strobe logs for the literal checks
  logic [2:0]    typ0 [$];
  logic [DW-1:0] dat0 [$];
  logic          xb0  [$];
  int unsigned   cy0  [$];
  logic [2:0]    typ1 [$];
  logic          xb1  [$];
  int            fd0_n = 0, fd1_n = 0;
  int unsigned   fd0_cyc = 0;

  always @(negedge clk) begin
    if (h[0].new_image | h[0].new_column | h[0].next_data) begin
      typ0.push_back({h[0].new_image, h[0].new_column, h[0].next_data});
      dat0.push_back(h[0].data_in);
      xb0.push_back(h[0].extra_bit);
      cy0.push_back(cyc);
    end
    if (h[1].new_image | h[1].new_column | h[1].next_data) begin
      typ1.push_back({h[1].new_image, h[1].new_column, h[1].next_data});
      xb1.push_back(h[1].extra_bit);
    end
    if (h[0].frame_done) begin fd0_n++; fd0_cyc = cyc; end
    if (h[1].frame_done) fd1_n++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    typ0.delete(); dat0.delete(); xb0.delete(); cy0.delete();
    typ1.delete(); xb1.delete();
    fd0_n = 0; fd1_n = 0;
  endtask

  task automatic pulse(ref logic s);
    @(posedge clk); #2 s = 1'b1;
    @(posedge clk); #2 s = 1'b0;
  endtask

  int unsigned e0;

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1; e0 = cyc + 1;
    @(posedge clk); #2 start = 1'b0;
    chk("E0 rd_en", h[0].rd_en, 1);
    chk("E0 rd_addr", h[0].rd_addr, 0);
    chk("E0 busy", h[0].busy, 1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    do begin
      @(posedge clk); #2;
      k++;
    end while ((h[0].busy || h[1].busy || h[0].frame_done || h[1].frame_done) && k < budget);
    chk({nm, " idle within budget"}, {h[0].busy, h[1].busy, h[0].frame_done, h[1].frame_done}, 0);
  endtask

  logic [2:0] exp_t0 [4] = '{3'b100, 3'b001, 3'b010, 3'b001};
  logic [2:0] exp_t1 [3] = '{3'b100, 3'b010, 3'b010};

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    chk("reset busy", h[0].busy, 0);

    // basic frame, tx_finish tied high, start mid-frame and in frame_done cycle ignored
    pulse(load_lit);
    fd_echo = 1'b1;
    clear_logs();
    pulse_start();
    repeat (5) @(posedge clk);
    pulse(start);
    wait_idle(100, "basic");
    repeat (10) @(posedge clk);
    #2;
    fd_echo = 1'b0;
    chk("basic strobe count", typ0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < typ0.size()) begin
        chk($sformatf("basic type[%0d]", i), typ0[i], exp_t0[i]);
        chk($sformatf("basic data[%0d]", i), dat0[i], lit[i]);
        chk($sformatf("basic extra_bit[%0d]", i), xb0[i], i % 2);
        chk($sformatf("basic strobe cycle[%0d]", i), cy0[i], e0 + 3 * (i + 1));
      end
    end
    chk("basic frame_done count", fd0_n, 1);
    chk("basic frame_done cycle", fd0_cyc, e0 + 15);
    chk("basic busy after", h[0].busy, 0);
    chk("single-word strobe count", typ1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < typ1.size()) begin
        chk($sformatf("single-word type[%0d]", i), typ1[i], exp_t1[i]);
        chk($sformatf("single-word extra_bit[%0d]", i), xb1[i], 1);
      end
    end
    chk("single-word frame_done count", fd1_n, 1);

    // backpressure: tx_finish low for 20 cycles after every strobe
    pulse(reload);
    bp_max = 20;
    clear_logs();
    pulse_start();
    wait_idle(400, "backpressure");
    chk("bp strobe count", typ0.size(), 4);
    if (typ0.size() == 4) begin
      chk("bp first strobe cycle", cy0[0], e0 + 3);
      for (int i = 1; i < 4; i++) chk($sformatf("bp spacing[%0d]", i), cy0[i] - cy0[i-1], 21);
      chk("bp frame_done cycle", fd0_cyc, cy0[3] + 21);
    end
    chk("bp frame_done count", fd0_n, 1);

    // reset after the second strobe, then replay from address 0
    bp_max = 0;
    pulse(load_lit);
    clear_logs();
    pulse_start();
    for (int k = 0; k < 50 && typ0.size() < 2; k++) begin
      @(posedge clk); #2;
    end
    chk("pre-reset strobes", typ0.size(), 2);
    rst = 1'b0;
    #1;
    chk("reset outputs", {h[0].rd_en, h[0].rd_addr, h[0].data_in, h[0].new_image, h[0].new_column,
                          h[0].next_data, h[0].extra_bit, h[0].busy, h[0].frame_done}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) @(posedge clk);
    chk("no frame_done after reset", fd0_n, 0);
    clear_logs();
    pulse_start();
    wait_idle(100, "replay");
    chk("replay strobe count", typ0.size(), 4);
    if (typ0.size() > 0) begin
      chk("replay first type", typ0[0], 3'b100);
      chk("replay first data", dat0[0], 24'h0F0F0F);
    end

    // randomized frames, backpressure, echoed starts and mid-frame resets
    for (int f = 0; f < 25; f++) begin
      pulse(reload);
      bp_rand = 1'b1;
      bp_max  = $urandom_range(6, 0);
      fd_echo = 1'($urandom_range(1, 0));
      repeat ($urandom_range(4, 0)) @(posedge clk);
      pulse_start();
      if ($urandom_range(9, 0) < 3) begin
        repeat ($urandom_range(30, 1)) @(posedge clk);
        #2 rst = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #2 rst = 1'b1;
      end
      wait_idle(500, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
